// File: rtl/draw_bar_graph.sv
// Renders CH_NUM vertical bars over a flat background from the 800x600 timing stream.
// Latency: fixed 2 pclk from timing inputs to timing outputs and rgb_out; no stalls.
// Backpressure: none; free-running pixel stream. Optional macro BAR_ALARM_EN colours bars at/above ALARM_LEVEL.
module draw_bar_graph #(
  parameter int          CH_NUM      = 13,
  parameter int          X0          = 36,
  parameter int          BAR_W       = 40,
  parameter int          PITCH       = 56,
  parameter int          BASE_Y      = 580,
  parameter logic [11:0] BG_COLOR    = 12'h000,
  parameter logic [11:0] BAR_COLOR   = 12'h0F0,
  parameter logic [11:0] ALARM_COLOR = 12'hF00,
  parameter logic [11:0] ALARM_LEVEL = 12'd3072
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic [11:0] hcount_in,
  input  logic [11:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic        ch_we,
  input  logic [3:0]  ch_addr,
  input  logic [11:0] ch_data,
  output logic [11:0] hcount_out,
  output logic [11:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);

  logic [11:0] live_q   [CH_NUM];
  logic [11:0] shadow_q [CH_NUM];
  logic        vblnk_q;
  logic        copy_d;

  // Stage 1 state
  logic [11:0] hc1_q, vc1_q;
  logic        hs1_q, vs1_q, hb1_q, vb1_q;
  logic        in_col_q;
  logic [11:0] val_q;

  // Stage 2 state (drives the outputs directly)
  logic [11:0] hc2_q, vc2_q, rgb_q;
  logic        hs2_q, vs2_q, hb2_q, vb2_q;

  logic        in_col_d;
  logic [3:0]  ch_d;
  logic [12:0] vsum_d;
  logic        lit_d;
  logic [11:0] bar_color_d;
  logic [11:0] rgb_d;

  // Copy window opens on the first cycle of vertical blanking.
  assign copy_d = vblnk_in & ~vblnk_q;

  // Live channel registers follow host writes; out-of-range addresses are dropped.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < CH_NUM; k++) live_q[k] <= '0;
    end else if (ch_we && (int'(ch_addr) < CH_NUM)) begin
      live_q[ch_addr] <= ch_data;
    end
  end

  // Shadow snapshot at vblank rise; a same-cycle write lands in live only, so it shows next frame.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      vblnk_q <= 1'b0;
      for (int k = 0; k < CH_NUM; k++) shadow_q[k] <= '0;
    end else begin
      vblnk_q <= vblnk_in;
      if (copy_d) begin
        for (int k = 0; k < CH_NUM; k++) shadow_q[k] <= live_q[k];
      end
    end
  end

  // Column decode by comparator chain: each bar owns [X0+k*PITCH, X0+k*PITCH+BAR_W).
  always_comb begin
    in_col_d = 1'b0;
    ch_d     = '0;
    for (int k = 0; k < CH_NUM; k++) begin
      if (({1'b0, hcount_in} >= 13'(X0 + k * PITCH)) &&
          ({1'b0, hcount_in} <  13'(X0 + k * PITCH + BAR_W))) begin
        in_col_d = 1'b1;
        ch_d     = 4'(k);
      end
    end
  end

`ifdef BAR_ALARM_EN
  logic alarm_q;

  // Alarm compare is done alongside the value fetch so the latency stays at 2.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) alarm_q <= 1'b0;
    else     alarm_q <= (shadow_q[ch_d] >= ALARM_LEVEL);
  end

  assign bar_color_d = alarm_q ? ALARM_COLOR : BAR_COLOR;
`else
  logic unused_alarm;
  assign unused_alarm = ^{ALARM_COLOR, ALARM_LEVEL};
  assign bar_color_d  = BAR_COLOR;
`endif

  // Stage 1: register timing, column hit and the selected shadow value.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      hc1_q    <= '0;
      vc1_q    <= '0;
      hs1_q    <= 1'b0;
      vs1_q    <= 1'b0;
      hb1_q    <= 1'b0;
      vb1_q    <= 1'b0;
      in_col_q <= 1'b0;
      val_q    <= '0;
    end else begin
      hc1_q    <= hcount_in;
      vc1_q    <= vcount_in;
      hs1_q    <= hsync_in;
      vs1_q    <= vsync_in;
      hb1_q    <= hblnk_in;
      vb1_q    <= vblnk_in;
      in_col_q <= in_col_d;
      val_q    <= shadow_q[ch_d];
    end
  end

  // Bar covers rows BASE_Y-h+1..BASE_Y with h = value[11:3]; 13-bit sum so it cannot wrap.
  assign vsum_d = {1'b0, vc1_q} + {4'b0, val_q[11:3]};
  assign lit_d  = in_col_q && (vc1_q <= 12'(BASE_Y)) && (vsum_d > 13'(BASE_Y));

  // Colour priority: blanking forces black, then bar, then background.
  always_comb begin
    rgb_d = BG_COLOR;
    if (hb1_q || vb1_q) rgb_d = 12'h000;
    else if (lit_d)     rgb_d = bar_color_d;
  end

  // Stage 2: output registers.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      hc2_q <= '0;
      vc2_q <= '0;
      hs2_q <= 1'b0;
      vs2_q <= 1'b0;
      hb2_q <= 1'b0;
      vb2_q <= 1'b0;
      rgb_q <= '0;
    end else begin
      hc2_q <= hc1_q;
      vc2_q <= vc1_q;
      hs2_q <= hs1_q;
      vs2_q <= vs1_q;
      hb2_q <= hb1_q;
      vb2_q <= vb1_q;
      rgb_q <= rgb_d;
    end
  end

  assign hcount_out = hc2_q;
  assign vcount_out = vc2_q;
  assign hsync_out  = hs2_q;
  assign vsync_out  = vs2_q;
  assign hblnk_out  = hb2_q;
  assign vblnk_out  = vb2_q;
  assign rgb_out    = rgb_q;

endmodule

// File: tb/tb_draw_bar_graph.sv
// Scoreboard bench for draw_bar_graph: every driven pixel queues its expected
// timing and colour, which are compared when they emerge 2 pclk later.
module tb_draw_bar_graph;

  localparam logic [11:0] BAR = 12'h0F0;
  localparam logic [11:0] BG  = 12'h000;
`ifdef BAR_ALARM_EN
  localparam logic [11:0] ALM = 12'hF00;
`else
  localparam logic [11:0] ALM = 12'h0F0;
`endif

  logic        pclk = 1'b0;
  logic        rst;
  logic [11:0] hcount_in, vcount_in, ch_data;
  logic        hsync_in, vsync_in, hblnk_in, vblnk_in, ch_we;
  logic [3:0]  ch_addr;
  logic [11:0] hcount_out, vcount_out, rgb_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;

  draw_bar_graph dut (
    .pclk(pclk), .rst(rst),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .ch_we(ch_we), .ch_addr(ch_addr), .ch_data(ch_data),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out),
    .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic [11:0] rgb;
    logic [27:0] tim;
    int          due;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;
  int   live_m [13];
  int   sh_m   [13];
  bit   prev_vb = 1'b0;

  always @(posedge pclk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference colour straight from the bar geometry (uses division, unlike the DUT).
  function automatic logic [11:0] model_rgb(int h, int v, bit hb, bit vb);
    int c, val;
    if (hb || vb) return 12'h000;
    if (h < 36) return BG;
    c = (h - 36) / 56;
    if (c >= 13 || ((h - 36) % 56) >= 40) return BG;
    val = sh_m[c];
    if (v <= 580 && v + (val >> 3) > 580) return (val >= 3072) ? ALM : BAR;
    return BG;
  endfunction

  // Compare outputs whose due cycle has arrived.
  always @(negedge pclk) begin
    while (exp_q.size() != 0 && exp_q[0].due < cyc) begin
      check("late", 32'(exp_q[0].due), 32'(cyc));
      void'(exp_q.pop_front());
    end
    if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
      check("rgb", 32'(rgb_out), 32'(exp_q[0].rgb));
      check("timing", 32'({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}),
            32'(exp_q[0].tim));
      void'(exp_q.pop_front());
    end
  end

  // One pixel cycle; fix < 0 uses the model, otherwise fix is the required colour.
  task automatic step(int h, int v, bit hs, bit vs, bit hb, bit vb,
                      bit we, int addr, int data, int fix);
    exp_t e;
    e.rgb = (fix >= 0) ? 12'(fix) : model_rgb(h, v, hb, vb);
    e.tim = {12'(h), 12'(v), hs, vs, hb, vb};
    e.due = cyc + 2;
    exp_q.push_back(e);
    if (vb && !prev_vb) for (int k = 0; k < 13; k++) sh_m[k] = live_m[k];
    if (we && addr < 13) live_m[addr] = data;
    prev_vb   = vb;
    hcount_in = 12'(h);
    vcount_in = 12'(v);
    hsync_in  = hs;
    vsync_in  = vs;
    hblnk_in  = hb;
    vblnk_in  = vb;
    ch_we     = we;
    ch_addr   = 4'(addr);
    ch_data   = 12'(data);
    @(negedge pclk);
  endtask

  task automatic vis(int h, int v);
    step(h, v, 0, 0, 0, 0, 0, 0, 0, -1);
  endtask

  task automatic pt(int h, int v, int fix);
    step(h, v, 0, 0, 0, 0, 0, 0, 0, fix);
  endtask

  task automatic row(int v, int h0, int h1);
    for (int h = h0; h <= h1; h++) vis(h, v);
  endtask

  task automatic wr(int addr, int data);
    step(1000, 10, 0, 0, 1, 0, 1, addr, data, -1);
  endtask

  // Short vertical blanking burst; the optional write lands on the copy cycle.
  task automatic frame_edge(bit we, int addr, int data);
    step(1000, 599, 1, 0, 1, 0, 0, 0, 0, -1);
    step(0, 601, 0, 1, 1, 1, we, addr, data, -1);
    step(1, 602, 1, 1, 1, 1, 0, 0, 0, -1);
    step(900, 605, 0, 0, 1, 1, 0, 0, 0, -1);
    step(1055, 627, 1, 0, 1, 1, 0, 0, 0, -1);
    step(850, 0, 1, 0, 1, 0, 0, 0, 0, -1);
  endtask

  initial begin
    rst = 1'b1;
    hcount_in = '0; vcount_in = '0; hsync_in = 1'b0; vsync_in = 1'b0;
    hblnk_in = 1'b0; vblnk_in = 1'b0; ch_we = 1'b0; ch_addr = '0; ch_data = '0;
    for (int k = 0; k < 13; k++) begin live_m[k] = 0; sh_m[k] = 0; end
    repeat (2) @(negedge pclk);
    check("reset_rgb", 32'(rgb_out), 32'h0);
    check("reset_timing", 32'({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}), 32'h0);
    rst = 1'b0;

    // Full-height bar on channel 0.
    wr(0, 4095);
    frame_edge(0, 0, 0);
    pt(36, 580, BAR);
    pt(36, 70, BAR);
    pt(36, 69, BG);
    pt(76, 300, BG);
    pt(35, 580, BG);
    row(70, 30, 80);
    row(69, 30, 80);
    step(40, 300, 1, 0, 1, 0, 0, 0, 0, 12'h000);
    vis(40, 300);
    vis(41, 300);

    // Asynchronous reset mid-frame.
    #2 rst = 1'b1;
    exp_q.delete();
    #1;
    check("async_rst_rgb", 32'(rgb_out), 32'h0);
    check("async_rst_timing", 32'({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}), 32'h0);
    @(negedge pclk);
    @(negedge pclk);
    for (int k = 0; k < 13; k++) begin live_m[k] = 0; sh_m[k] = 0; end
    prev_vb = 1'b0;
    rst = 1'b0;
    frame_edge(0, 0, 0);
    pt(36, 580, BG);
    row(580, 30, 80);

    // One-row bar, then zero height.
    wr(12, 8);
    frame_edge(0, 0, 0);
    pt(708, 580, BAR);
    pt(747, 580, BAR);
    pt(707, 580, BG);
    pt(748, 580, BG);
    pt(708, 579, BG);
    for (int v = 579; v <= 581; v++) row(v, 700, 755);
    wr(12, 7);
    frame_edge(0, 0, 0);
    pt(708, 580, BG);
    row(580, 700, 755);

    // Write during visible line does not tear the current frame.
    for (int h = 190; h <= 250; h++) step(h, 300, 0, 0, 0, 0, h == 200, 3, 2048, -1);
    pt(204, 400, BG);
    frame_edge(0, 0, 0);
    pt(204, 325, BAR);
    pt(243, 580, BAR);
    pt(204, 324, BG);
    pt(244, 400, BG);
    row(325, 198, 250);

    // Out-of-range addresses ignored; copy-cycle write deferred one frame.
    frame_edge(1, 13, 4095);
    row(580, 740, 800);
    frame_edge(1, 15, 4095);
    row(580, 740, 800);
    pt(764, 580, BG);
    frame_edge(1, 1, 1024);
    pt(92, 580, BG);
    row(580, 88, 135);
    frame_edge(0, 0, 0);
    pt(92, 580, BAR);
    pt(131, 453, BAR);
    pt(131, 452, BG);

    // Alarm threshold boundary on channel 5.
    wr(5, 3072);
    frame_edge(0, 0, 0);
    pt(316, 580, ALM);
    pt(355, 197, ALM);
    pt(355, 196, BG);
    step(316, 580, 1, 0, 1, 0, 0, 0, 0, 12'h000);
    step(316, 580, 0, 1, 0, 1, 0, 0, 0, 12'h000);
    wr(5, 3071);
    frame_edge(0, 0, 0);
    pt(316, 580, BAR);
    pt(355, 198, BAR);
    pt(316, 197, BG);

    repeat (6) @(negedge pclk);
    check("drain", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/draw_bar_graph.md
Name: draw_bar_graph

Overview:
Pixel-stream stage directly downstream of the 800x600@60 timing generator (40 MHz pclk).
- Consumes hcount/vcount/sync/blank and renders CH_NUM vertical voltage bars over a flat background.
- Produces delayed timing plus 12-bit RGB (4:4:4) for the VGA output stage.
- Channel values are written asynchronously to the frame. They are shadowed at the start of vertical blanking so a displayed frame never tears.

Parameters:
CH_NUM, 13, number of bars/channels (address width fixed at 4 bits)
X0, 36, hcount of left edge of channel 0 bar
BAR_W, 40, bar width in pixels
PITCH, 56, horizontal distance between left edges of adjacent bars
BASE_Y, 580, vcount of bar baseline (bottom-most lit row)
BG_COLOR, 12'h000, visible-area background colour
BAR_COLOR, 12'h0F0, normal bar colour
ALARM_COLOR, 12'hF00, bar colour at/above ALARM_LEVEL (optional feature only)
ALARM_LEVEL, 12'd3072, alarm threshold on raw channel value

Ports:
pclk  in  1  pixel clock, 40 MHz
rst  in  1  asynchronous, active-high reset
hcount_in  in  12  horizontal counter from timing stage
vcount_in  in  12  vertical counter from timing stage
hsync_in  in  1  horizontal sync
vsync_in  in  1  vertical sync
hblnk_in  in  1  horizontal blank
vblnk_in  in  1  vertical blank
ch_we  in  1  channel value write strobe, single-cycle
ch_addr  in  4  channel index for write
ch_data  in  12  channel value (raw ADC code, 0..4095)
hcount_out  out  12  hcount_in delayed 2 cycles
vcount_out  out  12  vcount_in delayed 2 cycles
hsync_out  out  1  hsync_in delayed 2 cycles
vsync_out  out  1  vsync_in delayed 2 cycles
hblnk_out  out  1  hblnk_in delayed 2 cycles
vblnk_out  out  1  vblnk_in delayed 2 cycles
rgb_out  out  12  pixel colour, aligned with *_out timing

Behaviour:
Reset:
- On rst high, asynchronously clear all outputs, pipeline registers, live and shadow value registers, and the vblnk edge register to 0.

Writes:
- On ch_we with ch_addr < CH_NUM, the live register [ch_addr] takes ch_data on the next pclk edge.
- Writes with ch_addr >= CH_NUM are ignored; no state changes.
- Back-to-back writes on consecutive cycles are all accepted.

Shadow update:
- Register vblnk_in. A rising edge (vblnk_in=1, previous=0) copies all live registers into the shadow registers in that cycle.
- If a write coincides with the copy cycle, the shadow gets the pre-write live value. The new value shows from the following frame.
- Rendering uses shadow registers only.

Pipeline (fixed latency 2, stall-free):
- Stage 1 registers:
  - channel index ch = (hcount - X0) / PITCH and offset = (hcount - X0) mod PITCH, derived without a divider (counter or comparator chain).
  - in_col = hcount >= X0 && ch < CH_NUM && offset < BAR_W.
  - the selected shadow value.
  - delayed timing.
- Stage 2:
  - height h = value[11:3] (0..511).
  - lit = in_col && vcount <= BASE_Y && vcount + h > BASE_Y, i.e. rows BASE_Y-h+1..BASE_Y.
  - h = 0 draws nothing.
  - Use a 13-bit sum so nothing wraps.
- Colour select, in priority order:
  - If hblnk or vblnk (stage-1 copy), rgb_out = 12'h000.
  - Else if lit, rgb_out = BAR_COLOR.
  - Else rgb_out = BG_COLOR.

Counter wrap:
- At hcount 1055->0 or vcount 627->0 no special handling is needed; all blank regions output 0.

Optional Feature:
Macro BAR_ALARM_EN.
- Defined: a lit pixel whose shadow value >= ALARM_LEVEL uses ALARM_COLOR instead of BAR_COLOR. The compare is registered in stage 1, so latency stays 2.
- Undefined: ALARM_COLOR and ALARM_LEVEL are unused and all bars use BAR_COLOR.

Test Plan:
1. Assert rst mid-frame with ch0 shadow=4095 -> all outputs 0 immediately (asynchronous). After release, first visible frame draws no bars; rgb_out=BG_COLOR wherever visible.
2. Write ch0=4095, run one vblnk edge, then scan the frame:
   - (36,580) and (36,70) -> BAR_COLOR.
   - (36,69), (76,300) and (35,580) -> BG_COLOR.
   - Every output appears exactly 2 pclk after its input.
3. Write ch12=8 (h=1) -> only pixel row 580, x 708..747 lit. Write ch12=7 (h=0) -> nothing lit.
4. During visible line 300, write ch3=2048 -> current frame unchanged. After the next vblnk rising edge, x 204..243 lit for rows 325..580.
5. Write ch_addr=13 or 15 with data 4095 on the copy cycle, plus ch1=1024 on the same copy cycle -> no bar changes for addr 13/15. ch1 appears only one frame later.
6. BAR_ALARM_EN defined: ch5=3072 -> bar pixels 12'hF00; ch5=3071 -> 12'h0F0. Blank regions are always 12'h000.
